// File: rtl/cascade_slave_responder_pkg.sv
// Shared types and defaults for the 8259A slave-side cascade responder.
package cascade_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    PULSE1,
    GAP,
    PULSE2
  } cas_state_t;

  localparam logic SP_MASTER = 1'b1;
  localparam logic SP_SLAVE  = 1'b0;

  localparam int CAS_SETTLE_DEF  = 2;
  localparam int GAP_TIMEOUT_DEF = 64;
  localparam int TIMER_W_DEF     = 7;

endpackage

// File: rtl/cascade_slave_responder_if.sv
// Cascade/INTA bus bundle between the CPU side and a slave responder.
interface cascade_slave_responder_if;

  logic       inta_n;
  logic [2:0] CAS;
  logic [7:0] data_out;
  logic       data_oe;

  modport slave (
    input  inta_n,
    input  CAS,
    output data_out,
    output data_oe
  );

  modport master (
    output inta_n,
    output CAS,
    input  data_out,
    input  data_oe
  );

endinterface

// File: rtl/inta_edge_detect.sv
// Registered INTA edge detector; shared with the master-side sequencer.
module inta_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic inta_n,
  output logic fall,
  output logic rise
);

  logic inta_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inta_prev <= 1'b1;
    else       inta_prev <= inta_n;
  end

  assign fall = inta_prev & ~inta_n;
  assign rise = ~inta_prev & inta_n;

endmodule

// File: rtl/cascade_slave_responder.sv
// Slave-side 8259A cascade responder: samples CAS after INTA pulse 1,
// drives the latched vector during pulse 2 when addressed.
module cascade_slave_responder
  import cascade_pkg::*;
#(
  parameter int CAS_SETTLE  = CAS_SETTLE_DEF,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF,
  parameter int TIMER_W     = TIMER_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SP,
  input  logic [2:0] slave_id,
  input  logic       int_pending,
  input  logic [7:0] vector_in,
  input  logic [2:0] level_in,
  cascade_slave_responder_if.slave bus,
  output logic       selected,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_level,
  output logic       seq_err
);

  localparam logic [TIMER_W-1:0] SETTLE_LD =
    TIMER_W'(CAS_SETTLE - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST =
    TIMER_W'(GAP_TIMEOUT - 1);

  logic fall, rise, match;
  cas_state_t state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic sel_q, sel_d, oe_q, oe_d;
  logic [7:0] vec_q, vec_d;
  logic [2:0] lvl_q, lvl_d;
  logic fz_q, fz_d, isr_q, isr_d, err_q, err_d;

  inta_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .inta_n (bus.inta_n),
    .fall   (fall),
    .rise   (rise)
  );

  // X/Z on CAS must never select this slave
  assign match = (bus.CAS === slave_id) & int_pending;
  assign timer_inc = timer_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    sel_d   = sel_q;
    oe_d    = oe_q;
    vec_d   = vec_q;
    lvl_d   = lvl_q;
    fz_d    = 1'b0;
    isr_d   = 1'b0;
    err_d   = 1'b0;
    if (SP == SP_MASTER) begin
      state_d = IDLE;
      timer_d = '0;
      sel_d   = 1'b0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fall) begin
            timer_d = SETTLE_LD;
            state_d = SAMPLE;
          end
        end
        SAMPLE: begin
          if (rise) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (timer_q == '0) begin
            fz_d    = 1'b1;
            sel_d   = match;
            state_d = PULSE1;
            if (match) begin
              vec_d = vector_in;
              lvl_d = level_in;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        PULSE1: begin
          if (rise) begin
            timer_d = '0;
            state_d = GAP;
          end
        end
        GAP: begin
          // a fall on the last gap cycle still wins over the timeout
          if (fall) begin
            oe_d    = sel_q;
            state_d = PULSE2;
          end else if (timer_inc == GAP_LAST) begin
            err_d   = 1'b1;
            sel_d   = 1'b0;
            timer_d = '0;
            state_d = IDLE;
          end else begin
            timer_d = timer_inc;
          end
        end
        PULSE2: begin
          if (rise) begin
            oe_d    = 1'b0;
            isr_d   = sel_q;
            sel_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      sel_q   <= 1'b0;
      oe_q    <= 1'b0;
      vec_q   <= 8'h00;
      lvl_q   <= 3'd0;
      fz_q    <= 1'b0;
      isr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      oe_q    <= oe_d;
      vec_q   <= vec_d;
      lvl_q   <= lvl_d;
      fz_q    <= fz_d;
      isr_q   <= isr_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_out = vec_q;
  assign bus.data_oe  = oe_q;
  assign selected     = sel_q;
  assign freeze       = fz_q;
  assign isr_set      = isr_q;
  assign isr_level    = lvl_q;
  assign seq_err      = err_q;

endmodule

// File: tb/tb_cascade_slave_responder.sv
// Directed bench: INTA waveforms vs an edge-index model of the responder.
module tb_cascade_slave_responder;
  import cascade_pkg::*;

  localparam int S  = 2;
  localparam int GT = 64;
  localparam int N  = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic       SP;
  logic [2:0] slave_id;
  logic       int_pending;
  logic [7:0] vector_in;
  logic [2:0] level_in;
  logic       selected, freeze, isr_set, seq_err;
  logic [2:0] isr_level;

  cascade_slave_responder_if bus ();

  cascade_slave_responder #(
    .CAS_SETTLE  (S),
    .GAP_TIMEOUT (GT),
    .TIMER_W     (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SP          (SP),
    .slave_id    (slave_id),
    .int_pending (int_pending),
    .vector_in   (vector_in),
    .level_in    (level_in),
    .bus         (bus),
    .selected    (selected),
    .freeze      (freeze),
    .isr_set     (isr_set),
    .isr_level   (isr_level),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  logic       w [N];
  int         len;
  bit         e_fz [N], e_isr [N], e_err [N];
  bit         e_sel [N], e_oe [N], e_lat [N];
  logic [7:0] e_dout [N];
  logic [2:0] e_lvl [N];
  logic [7:0] m_vec;
  logic [2:0] m_lvl;

  int  idx;
  bit  run;
  int  n_chk, n_pass;
  int  o_fz_cnt, o_fz_at, o_oe_cnt, o_isr_cnt, o_isr_at;
  int  o_err_cnt, o_err_at, o_sel_cnt;
  logic [2:0] o_isr_lvl;
  logic [7:0] o_oe_dout;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic lv, input int n);
    for (int k = 0; k < n; k++) begin
      w[len] = lv;
      len++;
    end
  endtask

  function automatic int find_edge(input logic lv, input int from);
    logic prev;
    for (int i = from; i < len; i++) begin
      prev = (i == 0) ? 1'b1 : w[i-1];
      if (w[i] == lv && prev != lv) return i;
    end
    return -1;
  endfunction

  // Expected outputs after each edge, derived from INTA edge positions
  task automatic build(input logic sp, input logic [2:0] cas);
    int p, f1, r1, c, f2, r2, fin;
    bit sel;
    for (int i = 0; i < N; i++) begin
      e_fz[i] = 0; e_isr[i] = 0; e_err[i] = 0;
      e_sel[i] = 0; e_oe[i] = 0; e_lat[i] = 0;
    end
    p = 0;
    while (!sp && p < len) begin
      f1 = find_edge(1'b0, p);
      if (f1 < 0) break;
      r1 = find_edge(1'b1, f1 + 1);
      if (r1 < 0) break;
      c = f1 + S;
      if (r1 <= c) begin
        e_err[r1] = 1;
        p = r1 + 1;
        continue;
      end
      e_fz[c] = 1;
      sel = (cas === slave_id) && int_pending;
      e_lat[c] = sel;
      f2 = find_edge(1'b0, r1 + 1);
      if (f2 < 0 || f2 > r1 + GT - 1) begin
        fin = r1 + GT - 1;
        if (fin < len) e_err[fin] = 1;
        for (int i = c; i < fin && i < len; i++) e_sel[i] = sel;
        p = fin + 1;
        continue;
      end
      r2 = find_edge(1'b1, f2 + 1);
      if (r2 < 0) r2 = len;
      for (int i = c; i < r2; i++) e_sel[i] = sel;
      for (int i = f2; i < r2; i++) e_oe[i] = sel;
      if (r2 < len) e_isr[r2] = sel;
      p = r2 + 1;
    end
    for (int i = 0; i < len; i++) begin
      if (e_lat[i]) begin
        m_vec = vector_in;
        m_lvl = level_in;
      end
      e_dout[i] = m_vec;
      e_lvl[i]  = m_lvl;
    end
  endtask

  always @(posedge clk) begin
    if (run) begin
      logic [15:0] act, exp;
      #1;
      act = {freeze, isr_set, seq_err, selected,
             bus.data_oe, bus.data_out, isr_level};
      exp = {e_fz[idx], e_isr[idx], e_err[idx], e_sel[idx],
             e_oe[idx], e_dout[idx], e_lvl[idx]};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL cyc idx=%0d got %h expected %h", idx, act, exp);
      if (freeze) begin o_fz_cnt++; o_fz_at = idx; end
      if (bus.data_oe) begin o_oe_cnt++; o_oe_dout = bus.data_out; end
      if (isr_set) begin
        o_isr_cnt++; o_isr_at = idx; o_isr_lvl = isr_level;
      end
      if (seq_err) begin o_err_cnt++; o_err_at = idx; end
      if (selected) o_sel_cnt++;
    end
  end

  task automatic run_wave(input logic sp, input logic [2:0] cas,
                          input int stop_at);
    int last;
    build(sp, cas);
    o_fz_cnt = 0; o_fz_at = -1; o_oe_cnt = 0; o_isr_cnt = 0;
    o_isr_at = -1; o_err_cnt = 0; o_err_at = -1; o_sel_cnt = 0;
    o_isr_lvl = 0; o_oe_dout = 0;
    @(negedge clk);
    SP = sp;
    bus.CAS = cas;
    last = (stop_at < 0) ? len : stop_at + 1;
    for (int i = 0; i < last; i++) begin
      @(negedge clk);
      idx = i;
      bus.inta_n = w[i];
      run = 1;
    end
    @(negedge clk);
    run = 0;
  endtask

  task automatic std_wave();
    len = 0;
    add(1'b1, 2); add(1'b0, 4); add(1'b1, 3);
    add(1'b0, 4); add(1'b1, 4);
  endtask

  initial begin
    n_chk = 0; n_pass = 0; run = 0; idx = 0;
    reset = 1'b1; SP = SP_SLAVE; slave_id = 3'd3;
    int_pending = 1'b1; vector_in = 8'h4A; level_in = 3'd5;
    bus.inta_n = 1'b1; bus.CAS = 3'd0;
    m_vec = 8'h00; m_lvl = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_outs",
          {freeze, isr_set, seq_err, selected, bus.data_oe,
           bus.data_out, isr_level}, 0);
    reset = 1'b0;

    std_wave();
    run_wave(SP_MASTER, 3'd3, -1);
    check("sp1_freeze", o_fz_cnt, 0);
    check("sp1_oe", o_oe_cnt, 0);

    std_wave();
    run_wave(SP_SLAVE, 3'd3, -1);
    check("match_freeze_at", o_fz_at, 4);
    check("match_oe_cycles", o_oe_cnt, 4);
    check("match_oe_data", o_oe_dout, 8'h4A);
    check("match_isr_at", o_isr_at, 13);
    check("match_isr_lvl", o_isr_lvl, 5);

    vector_in = 8'h33; level_in = 3'd2;
    std_wave();
    run_wave(SP_SLAVE, 3'd6, -1);
    check("nomatch_sel", o_sel_cnt, 0);
    check("nomatch_oe", o_oe_cnt, 0);
    check("nomatch_isr", o_isr_cnt, 0);
    check("nomatch_freeze", o_fz_cnt, 1);
    check("nomatch_dout", bus.data_out, 8'h4A);

    len = 0; add(1'b1, 2); add(1'b0, 1); add(1'b1, 4);
    run_wave(SP_SLAVE, 3'd3, -1);
    check("short1_err_at", o_err_at, 3);
    check("short1_freeze", o_fz_cnt, 0);

    len = 0; add(1'b1, 2); add(1'b0, 2); add(1'b1, 4);
    run_wave(SP_SLAVE, 3'd3, -1);
    check("short2_err_at", o_err_at, 4);

    vector_in = 8'h4A; level_in = 3'd5;
    len = 0; add(1'b1, 2); add(1'b0, 4); add(1'b1, 66);
    run_wave(SP_SLAVE, 3'd3, -1);
    check("timeout_err_at", o_err_at, 69);
    check("timeout_isr", o_isr_cnt, 0);

    len = 0; add(1'b1, 2); add(1'b0, 4); add(1'b1, 63);
    add(1'b0, 3); add(1'b1, 3);
    run_wave(SP_SLAVE, 3'd3, -1);
    check("gap63_err", o_err_cnt, 0);
    check("gap63_isr", o_isr_cnt, 1);

    vector_in = 8'h5C; level_in = 3'd1;
    std_wave();
    run_wave(SP_SLAVE, 3'd3, -1);
    check("after_to_isr", o_isr_cnt, 1);
    check("after_to_data", o_oe_dout, 8'h5C);

    std_wave();
    run_wave(SP_SLAVE, 3'd3, 10);
    check("pre_rst_oe", bus.data_oe, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_oe", bus.data_oe, 0);
    check("rst_async_sel", selected, 0);
    bus.inta_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_vec = 8'h00; m_lvl = 3'd0;
    repeat (3) @(negedge clk);
    check("post_rst_outs",
          {freeze, isr_set, seq_err, selected, bus.data_oe,
           bus.data_out, isr_level}, 0);

    vector_in = 8'h91; level_in = 3'd7;
    std_wave();
    run_wave(SP_SLAVE, 3'd3, -1);
    check("post_rst_isr_lvl", o_isr_lvl, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
